// File: rtl/spi_ram_cmd_engine.sv
// Command-decoded RAM behind an SPI slave: address/write/read opcodes, self-clearing
// memory after reset, sticky out-of-range flag and a held read result with backpressure.
module spi_ram_cmd_engine #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic                 auto_inc,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 addr_err,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {StClear, StIdle, StHold} state_e;

  localparam logic [ADDR_SIZE-1:0] LastAddr = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   Depth    = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 addr_err_q, addr_err_d;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic                 set_err;

  logic [1:0]           opcode;
  logic [DATA_SIZE-1:0] payload;
  logic [ADDR_SIZE-1:0] addr_p;
  logic                 addr_ok;

  assign opcode  = din[DATA_SIZE+1:DATA_SIZE];
  assign payload = din[DATA_SIZE-1:0];
  assign addr_p  = din[ADDR_SIZE-1:0];
  assign addr_ok = {1'b0, addr_p} < Depth;

  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    return (p == LastAddr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    clr_cnt_d  = clr_cnt_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    mem_wdata  = payload;
    set_err    = 1'b0;

    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LastAddr) begin
          clr_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      StIdle: begin
        if (rx_valid) begin
          unique case (opcode)
            2'b00: begin
              if (addr_ok) wr_ptr_d = addr_p;
              else         set_err  = 1'b1;
            end
            2'b01: begin
              mem_we = 1'b1;
              if (auto_inc) wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            2'b10: begin
              if (addr_ok) rd_ptr_d = addr_p;
              else         set_err  = 1'b1;
            end
            2'b11: begin
              dout_d     = mem[rd_ptr_q];
              tx_valid_d = 1'b1;
              state_d    = StHold;
              if (auto_inc) rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            default: ;
          endcase
        end
      end
      StHold: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StClear;
    endcase

    // A new error in the same cycle as err_clr must survive.
    if (set_err)      addr_err_d = 1'b1;
    else if (err_clr) addr_err_d = 1'b0;
    else              addr_err_d = addr_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      clr_cnt_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rx_ready = (state_q == StIdle);
  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign addr_err = addr_err_q;

endmodule
